// File: rtl/hamming_pkg.sv
// Shared constants for the Hamming(32,26) SECDED encoder/decoder pair.
// Check masks, parity/data index maps and the encoder FSM encoding.
package hamming_pkg;

  localparam int DW   = 26;
  localparam int CW   = 32;
  localparam int NCHK = 5;
  localparam int NPAR = 6;

  localparam logic [CW-1:0] CHK_MASK [NCHK] = '{
    32'hAAAAAAAA,
    32'hCCCCCCCC,
    32'hF0F0F0F0,
    32'hFF00FF00,
    32'hFFFF0000
  };

  localparam int PAR_IDX [NPAR] = '{0, 1, 3, 7, 15, 31};

  localparam int DATA_IDX [DW] = '{
    2, 4, 5, 6,
    8, 9, 10, 11, 12, 13, 14,
    16, 17, 18, 19, 20, 21, 22, 23,
    24, 25, 26, 27, 28, 29, 30
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_OUT
  } state_t;

  function automatic logic [CW-1:0] place(
    input logic [DW-1:0] d
  );
    logic [CW-1:0] w;
    w = '0;
    for (int i = 0; i < DW; i++)
      w[DATA_IDX[i]] = d[i];
    return w;
  endfunction

endpackage

// File: rtl/hamming_encoder_if.sv
// Payload-in / codeword-out handshake bundle for hamming_encoder.
// Injection signals exist only with HAMMING_ERR_INJECT_EN.
interface hamming_encoder_if;
  logic [25:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] encoded_data;
  logic        out_valid;
  logic        out_ready;
`ifdef HAMMING_ERR_INJECT_EN
  logic [31:0] inj_mask;
  logic        inj_arm;

  modport master (
    output data_in, in_valid, out_ready,
    output inj_mask, inj_arm,
    input  in_ready, encoded_data, out_valid
  );
  modport slave (
    input  data_in, in_valid, out_ready,
    input  inj_mask, inj_arm,
    output in_ready, encoded_data, out_valid
  );
`else
  modport master (
    output data_in, in_valid, out_ready,
    input  in_ready, encoded_data, out_valid
  );
  modport slave (
    input  data_in, in_valid, out_ready,
    output in_ready, encoded_data, out_valid
  );
`endif
endinterface

// File: rtl/hamming_parity_gen.sv
// Check-set XORs and overall parity of a placed 32-bit word.
// Encoder uses it on data-only words; a decoder gets syndromes directly.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [CW-1:0]   word,
  output logic [NCHK-1:0] chk,
  output logic            ovr
);

  always_comb begin
    chk = '0;
    for (int k = 0; k < NCHK; k++)
      chk[k] = ^(word & CHK_MASK[k]);
    ovr = ^word;
  end

endmodule

// File: rtl/hamming_encoder.sv
// Hamming(32,26) SECDED encoder with IDLE/CALC/OUT handshake FSM.
// Optional error injection: HAMMING_ERR_INJECT_EN.
module hamming_encoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hamming_encoder_if.slave io,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  state_t           state_q, state_d;
  logic [CW-1:0]    word_q, word_d;
  logic [CW-1:0]    code_q, code_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef HAMMING_ERR_INJECT_EN
  logic             arm_q, arm_d;
  logic [CW-1:0]    mask_q, mask_d;
`endif

  logic [NCHK-1:0]  s;
  logic             dpar;
  logic [NPAR-1:0]  pb;
  logic [CW-1:0]    pw;

  hamming_parity_gen u_par (
    .word (word_q),
    .chk  (s),
    .ovr  (dpar)
  );

  // Triangular solve: b31 covers every check set, so solve top-down.
  always_comb begin
    pb    = '0;
    pb[5] = s[4];
    pb[4] = s[3] ^ pb[5];
    pb[3] = s[2] ^ pb[5] ^ pb[4];
    pb[2] = s[1] ^ pb[5] ^ pb[4] ^ pb[3];
    pb[1] = s[0] ^ pb[5] ^ pb[4] ^ pb[3] ^ pb[2];
    pb[0] = dpar ^ (^pb[5:1]);
    pw    = word_q;
    for (int i = 0; i < NPAR; i++)
      pw[PAR_IDX[i]] = pb[i];
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    code_d  = code_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
`ifdef HAMMING_ERR_INJECT_EN
    arm_d   = arm_q;
    mask_d  = mask_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          word_d  = place(io.data_in);
          state_d = ST_CALC;
`ifdef HAMMING_ERR_INJECT_EN
          arm_d   = io.inj_arm;
          mask_d  = io.inj_mask;
`endif
        end
      end
      ST_CALC: begin
`ifdef HAMMING_ERR_INJECT_EN
        code_d  = arm_q ? (pw ^ mask_q) : pw;
`else
        code_d  = pw;
`endif
        valid_d = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (io.out_ready) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef HAMMING_ERR_INJECT_EN
      arm_q   <= 1'b0;
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef HAMMING_ERR_INJECT_EN
      arm_q   <= arm_d;
      mask_q  <= mask_d;
`endif
    end
  end

  assign io.in_ready     = (state_q == ST_IDLE);
  assign io.encoded_data = code_q;
  assign io.out_valid    = valid_q;
  assign busy            = (state_q != ST_IDLE);
  assign word_count      = cnt_q;

endmodule

// File: tb/tb_hamming_encoder.sv
// Self-checking bench for hamming_encoder (CNT_W=4).
// Model encodes by searching parity patterns for a zero-syndrome word.
module tb_hamming_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [3:0] word_count;

  always #5 clk = ~clk;

  hamming_encoder_if ifc ();

  hamming_encoder #(.CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (ifc.slave),
    .busy       (busy),
    .word_count (word_count)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic bit is_par(input int i);
    return i == 0 || i == 1 || i == 3 ||
           i == 7 || i == 15 || i == 31;
  endfunction

  function automatic logic [4:0] syn(input logic [31:0] w);
    logic [4:0] s;
    s = '0;
    for (int i = 0; i < 32; i++)
      for (int k = 0; k < 5; k++)
        if ((i >> k) & 1) s[k] ^= w[i];
    return s;
  endfunction

  function automatic logic [31:0] put(input logic [25:0] d);
    logic [31:0] w;
    int j;
    w = '0;
    j = 0;
    for (int i = 0; i < 32; i++)
      if (!is_par(i)) begin
        w[i] = d[j];
        j++;
      end
    return w;
  endfunction

  function automatic logic [25:0] extract(input logic [31:0] w);
    logic [25:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < 32; i++)
      if (!is_par(i)) begin
        d[j] = w[i];
        j++;
      end
    return d;
  endfunction

  function automatic logic [31:0] enc(input logic [25:0] d);
    logic [31:0] w;
    logic [5:0]  p;
    for (int n = 0; n < 64; n++) begin
      p = 6'(n);
      w = put(d);
      w[0] = p[0]; w[1] = p[1]; w[3] = p[2];
      w[7] = p[3]; w[15] = p[4]; w[31] = p[5];
      if (syn(w) == 5'd0 && ^w == 1'b0) return w;
    end
    return 32'hDEADBEEF;
  endfunction

  logic        m_pend = 0, m_calc = 0, m_valid = 0;
  logic [31:0] m_code = 0;
  logic [3:0]  m_cnt = 0;
  logic [25:0] m_word = 0;
  logic        m_arm = 0;
  logic [31:0] m_mask = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_calc = 0; m_valid = 0;
      m_code = 0; m_cnt = 0; m_arm = 0;
    end else if (!m_pend) begin
      if (ifc.in_valid) begin
        m_pend = 1; m_calc = 1;
        m_word = ifc.data_in;
`ifdef HAMMING_ERR_INJECT_EN
        m_arm  = ifc.inj_arm;
        m_mask = ifc.inj_mask;
`endif
      end
    end else if (m_calc) begin
      m_calc  = 0;
      m_code  = enc(m_word) ^ (m_arm ? m_mask : 32'h0);
      m_valid = 1;
    end else if (ifc.out_ready) begin
      m_valid = 0; m_pend = 0;
      m_cnt   = m_cnt + 4'd1;
    end
  end

  always @(negedge clk) begin
    chk("cyc_out_valid", 32'(ifc.out_valid), 32'(m_valid));
    chk("cyc_code", ifc.encoded_data, m_code);
    chk("cyc_in_ready", 32'(ifc.in_ready), 32'(!m_pend));
    chk("cyc_busy", 32'(busy), 32'(m_pend));
    chk("cyc_count", 32'(word_count), 32'(m_cnt));
  end

  task automatic send(input logic [25:0] d, output logic [31:0] cw);
    int n;
    cw = '0;
    ifc.data_in  = d;
    ifc.in_valid = 1'b1;
    n = 0;
    while (!ifc.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("accept_timeout", 32'd0, 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("lat_edge1_valid", 32'(ifc.out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge2_valid", 32'(ifc.out_valid), 32'd1);
    cw = ifc.encoded_data;
  endtask

  logic [31:0] cw, hold;
  logic [25:0] d;

  initial begin
    ifc.data_in   = '0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
`ifdef HAMMING_ERR_INJECT_EN
    ifc.inj_mask  = '0;
    ifc.inj_arm   = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_code", ifc.encoded_data, 32'd0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);

    chk("model_zero", enc(26'h0), 32'h00000000);
    chk("model_one", enc(26'h1), 32'h0000000F);
    chk("model_ones", enc(26'h3FFFFFF), 32'hFFFFFFFF);

    send(26'h0000000, cw);
    chk("lit_zero", cw, 32'h00000000);
    @(negedge clk);
    send(26'h0000001, cw);
    chk("lit_one", cw, 32'h0000000F);
    @(negedge clk);
    send(26'h3FFFFFF, cw);
    chk("lit_ones", cw, 32'hFFFFFFFF);
    @(negedge clk);
    chk("count_three", 32'(word_count), 32'd3);

    ifc.out_ready = 1'b0;
    d = 26'h2A5C3F1;
    send(d, hold);
    chk("stall_code", hold, enc(d));
    ifc.data_in  = 26'h1234567;
    ifc.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", ifc.encoded_data, hold);
      chk("stall_valid", 32'(ifc.out_valid), 32'd1);
      chk("stall_in_ready", 32'(ifc.in_ready), 32'd0);
      chk("stall_count", 32'(word_count), 32'd3);
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    chk("release_count", 32'(word_count), 32'd4);
    chk("release_valid", 32'(ifc.out_valid), 32'd0);

    ifc.data_in  = 26'h0000155;
    ifc.in_valid = 1'b1;
    @(posedge clk);
    #1 ifc.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ifc.out_valid), 32'd0);
    chk("arst_code", ifc.encoded_data, 32'd0);
    chk("arst_count", 32'(word_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(ifc.out_valid), 32'd0);
      chk("post_rst_count", 32'(word_count), 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      d = 26'($urandom);
      send(d, cw);
      chk("rt_syndrome", 32'(syn(cw)), 32'd0);
      chk("rt_parity", 32'(^cw), 32'd0);
      chk("rt_payload", 32'(extract(cw)), 32'(d));
      @(negedge clk);
    end
    chk("count_wrap", 32'(word_count), 32'd0);

`ifdef HAMMING_ERR_INJECT_EN
    ifc.inj_arm  = 1'b1;
    ifc.inj_mask = 32'h00000100;
    send(26'h0000001, cw);
    ifc.inj_arm  = 1'b0;
    ifc.inj_mask = '0;
    chk("inj_code", cw, 32'h0000010F);
    chk("inj_syndrome", 32'(syn(cw)), 32'd8);
    chk("inj_single", 32'(^cw), 32'd1);
    @(negedge clk);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
